// File: rtl/traffic_signal_monitor.sv
// rtl/traffic_signal_monitor.sv - passive light-code checker for the two-road signal controller
// Decodes SA/SB into a phase, enforces order/exclusion/yellow dwell, latches first fault, counts cycles.
module traffic_signal_monitor #(
    parameter int YELLOW_CYCLES = 1,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       SA,
    input  logic [1:0]       SB,
    input  logic             clear_fault,
    output logic             running,
    output logic [1:0]       phase,
    output logic             fault,
    output logic [2:0]       fault_code,
    output logic [CNT_W-1:0] cycle_count
);

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    localparam logic [1:0] RED = 2'b00;
    localparam logic [1:0] YEL = 2'b01;
    localparam logic [1:0] GRN = 2'b10;
    localparam logic [1:0] BAD = 2'b11;
    localparam logic [3:0] W_YC = 4'(YELLOW_CYCLES);

    localparam logic [2:0] E_NONE     = 3'd0;
    localparam logic [2:0] E_CODE     = 3'd1;
    localparam logic [2:0] E_CONFLICT = 3'd2;
    localparam logic [2:0] E_ORDER    = 3'd3;
    localparam logic [2:0] E_Y_SHORT  = 3'd4;
    localparam logic [2:0] E_Y_LONG   = 3'd5;

    state_t           r_state;
    logic             r_running;
    logic [1:0]       r_phase;
    logic             r_fault;
    logic [2:0]       r_fault_code;
    logic [CNT_W-1:0] r_cycle_count;
    logic [3:0]       r_dwell;

    logic       w_bad_code;
    logic       w_legal;
    logic [1:0] w_sample;
    logic       w_change;
    logic       w_next_ok;
    logic       w_yellow;
    logic [2:0] w_err;
    logic [3:0] w_dwell_inc;

    always_comb begin
        w_legal  = 1'b1;
        w_sample = 2'd0;
        case ({SA, SB})
            {GRN, RED}: w_sample = 2'd0;
            {YEL, RED}: w_sample = 2'd1;
            {RED, GRN}: w_sample = 2'd2;
            {RED, YEL}: w_sample = 2'd3;
            default:    w_legal  = 1'b0;
        endcase
    end

    assign w_bad_code  = (SA == BAD) || (SB == BAD);
    assign w_change    = (w_sample != r_phase);
    assign w_next_ok   = (w_sample == r_phase + 2'd1);
    // P1 and P3 are the yellow phases; both have an odd phase code
    assign w_yellow    = r_phase[0];
    assign w_dwell_inc = (r_dwell == 4'hF) ? r_dwell : r_dwell + 4'd1;

    // Priority chain: encoding > conflict > order > yellow dwell
    always_comb begin
        w_err = E_NONE;
        if (w_bad_code) begin
            w_err = E_CODE;
        end else if (!w_legal) begin
            w_err = E_CONFLICT;
        end else if (r_state == ST_RUN) begin
            if (w_change && !w_next_ok) begin
                w_err = E_ORDER;
            end else if (w_yellow && w_change && (r_dwell < W_YC)) begin
                w_err = E_Y_SHORT;
            end else if (w_yellow && !w_change && (r_dwell == W_YC)) begin
                w_err = E_Y_LONG;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_INIT;
            r_running     <= 1'b0;
            r_phase       <= 2'd0;
            r_fault       <= 1'b0;
            r_fault_code  <= E_NONE;
            r_cycle_count <= '0;
            r_dwell       <= 4'd0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    if (w_err != E_NONE) begin
                        r_state      <= ST_FAULT;
                        r_fault      <= 1'b1;
                        r_fault_code <= w_err;
                    end else begin
                        r_phase <= w_sample;
                        if (w_sample == 2'd0) begin
                            r_state   <= ST_RUN;
                            r_running <= 1'b1;
                            r_dwell   <= 4'd1;
                        end
                    end
                end
                ST_RUN: begin
                    if (w_err != E_NONE) begin
                        r_state      <= ST_FAULT;
                        r_running    <= 1'b0;
                        r_fault      <= 1'b1;
                        r_fault_code <= w_err;
                    end else if (w_change) begin
                        r_phase <= w_sample;
                        r_dwell <= 4'd1;
                        if (r_phase == 2'd3 && w_sample == 2'd0) begin
                            r_cycle_count <= r_cycle_count + CNT_W'(1);
                        end
                    end else begin
                        r_dwell <= w_dwell_inc;
                    end
                end
                ST_FAULT: begin
                    // the sample on the clearing edge is discarded
                    if (clear_fault) begin
                        r_state      <= ST_INIT;
                        r_fault      <= 1'b0;
                        r_fault_code <= E_NONE;
                    end
                end
                default: begin
                    r_state   <= ST_INIT;
                    r_running <= 1'b0;
                    r_fault   <= 1'b0;
                end
            endcase
        end
    end

    assign running     = r_running;
    assign phase       = r_phase;
    assign fault       = r_fault;
    assign fault_code  = r_fault_code;
    assign cycle_count = r_cycle_count;

endmodule

// File: tb/tb_traffic_signal_monitor.sv
// tb/tb_traffic_signal_monitor.sv - self-checking bench for traffic_signal_monitor
// Instance A uses default parameters, instance B uses YELLOW_CYCLES=2 and a 4-bit counter.
module tb_traffic_signal_monitor;

    typedef struct {
        int mode;
        int ph;
        int dw;
        int code;
        int cnt;
    } mstate_t;

    logic       clk;
    logic       reset_n;
    logic [1:0] a_sa, a_sb, b_sa, b_sb;
    logic       a_clr, b_clr;
    logic       a_running, a_fault, b_running, b_fault;
    logic [1:0] a_phase, b_phase;
    logic [2:0] a_code, b_code;
    logic [7:0] a_cnt;
    logic [3:0] b_cnt;

    int n_cmp;
    int n_fail;
    mstate_t ma, mb;
    mstate_t m_zero;

    traffic_signal_monitor dut_a (
        .clk(clk), .reset_n(reset_n), .SA(a_sa), .SB(a_sb), .clear_fault(a_clr),
        .running(a_running), .phase(a_phase), .fault(a_fault),
        .fault_code(a_code), .cycle_count(a_cnt)
    );

    traffic_signal_monitor #(.YELLOW_CYCLES(2), .CNT_W(4)) dut_b (
        .clk(clk), .reset_n(reset_n), .SA(b_sa), .SB(b_sb), .clear_fault(b_clr),
        .running(b_running), .phase(b_phase), .fault(b_fault),
        .fault_code(b_code), .cycle_count(b_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] pair_of(int p);
        case (p)
            0:       return 4'b1000;
            1:       return 4'b0100;
            2:       return 4'b0010;
            default: return 4'b0001;
        endcase
    endfunction

    // Reference: mode 0 = INIT, 1 = RUN, 2 = FAULT
    function automatic mstate_t mstep(mstate_t s, logic [1:0] sa, logic [1:0] sb,
                                      logic clr, int ycyc, int cmod);
        mstate_t n;
        int p;
        int err;
        n = s;
        p = -1;
        for (int i = 0; i < 4; i++) if ({sa, sb} == pair_of(i)) p = i;
        if (s.mode == 2) begin
            if (clr) begin
                n.mode = 0;
                n.code = 0;
            end
            return n;
        end
        err = 0;
        if (sa == 2'b11 || sb == 2'b11) err = 1;
        else if (p < 0) err = 2;
        else if (s.mode == 1) begin
            if (p != s.ph) begin
                if (p != (s.ph + 1) % 4) err = 3;
                else if ((s.ph % 2 == 1) && s.dw < ycyc) err = 4;
            end else if ((s.ph % 2 == 1) && s.dw == ycyc) err = 5;
        end
        if (err != 0) begin
            n.mode = 2;
            n.code = err;
            return n;
        end
        if (s.mode == 0) begin
            n.ph = p;
            if (p == 0) begin
                n.mode = 1;
                n.dw = 1;
            end
        end else if (p == s.ph) begin
            n.dw = (s.dw < 15) ? s.dw + 1 : 15;
        end else begin
            if (s.ph == 3 && p == 0) n.cnt = (s.cnt + 1) % cmod;
            n.ph = p;
            n.dw = 1;
        end
        return n;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        ma = mstep(ma, a_sa, a_sb, a_clr, 1, 256);
        mb = mstep(mb, b_sa, b_sb, b_clr, 2, 16);
    endtask

    task automatic drive_a(int p, logic clr);
        {a_sa, a_sb} = pair_of(p);
        a_clr = clr;
        tick();
    endtask

    task automatic drive_b(int p, logic clr);
        {b_sa, b_sb} = pair_of(p);
        b_clr = clr;
        tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        {a_sa, a_sb} = 4'b1000;
        {b_sa, b_sb} = 4'b1000;
        a_clr = 1'b0;
        b_clr = 1'b0;
        ma = m_zero;
        mb = m_zero;
        repeat (3) @(posedge clk);
        #3;
        n_cmp++;
        if ({a_running, a_phase, a_fault, a_code, a_cnt} !== 15'd0) begin
            n_fail++;
            $display("FAIL reset_a got %b required 0", {a_running, a_phase, a_fault, a_code, a_cnt});
        end
        n_cmp++;
        if ({b_running, b_phase, b_fault, b_code, b_cnt} !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_b got %b required 0", {b_running, b_phase, b_fault, b_code, b_cnt});
        end
        reset_n = 1'b1;
    endtask

    task automatic test_cycle();
        int seq [8] = '{0, 0, 0, 1, 2, 2, 3, 0};
        for (int i = 0; i < 8; i++) begin
            drive_a(seq[i], 1'b0);
            n_cmp++;
            if (a_running !== 1'b1 || a_phase !== 2'(seq[i]) || a_fault !== 1'b0) begin
                n_fail++;
                $display("FAIL cycle_step%0d got run=%0d ph=%0d flt=%0d required run=1 ph=%0d flt=0",
                         i, a_running, a_phase, a_fault, seq[i]);
            end
        end
        n_cmp++;
        if (a_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL cycle_count got %0d required 1", a_cnt);
        end
    endtask

    task automatic test_conflict();
        {a_sa, a_sb} = 4'b1010;
        tick();
        n_cmp++;
        if (a_fault !== 1'b1 || a_code !== 3'd2 || a_phase !== 2'd0 || a_running !== 1'b0) begin
            n_fail++;
            $display("FAIL conflict got flt=%0d code=%0d ph=%0d run=%0d required 1 2 0 0",
                     a_fault, a_code, a_phase, a_running);
        end
        a_clr = 1'b1;
        tick();
        n_cmp++;
        if (a_fault !== 1'b0 || a_code !== 3'd0 || a_running !== 1'b0) begin
            n_fail++;
            $display("FAIL conflict_clear got flt=%0d code=%0d run=%0d required 0 0 0",
                     a_fault, a_code, a_running);
        end
        drive_a(0, 1'b0);
        n_cmp++;
        if (a_running !== 1'b1 || a_fault !== 1'b0) begin
            n_fail++;
            $display("FAIL conflict_rerun got run=%0d flt=%0d required 1 0", a_running, a_fault);
        end
    endtask

    task automatic test_priority();
        {a_sa, a_sb} = 4'b1111;
        tick();
        n_cmp++;
        if (a_code !== 3'd1 || a_fault !== 1'b1) begin
            n_fail++;
            $display("FAIL priority got code=%0d flt=%0d required 1 1", a_code, a_fault);
        end
        drive_a(0, 1'b1);
        drive_a(0, 1'b0);
    endtask

    task automatic test_transition();
        drive_a(0, 1'b0);
        drive_a(2, 1'b0);
        n_cmp++;
        if (a_code !== 3'd3 || a_cnt !== 8'd1 || a_phase !== 2'd0) begin
            n_fail++;
            $display("FAIL transition got code=%0d cnt=%0d ph=%0d required 3 1 0", a_code, a_cnt, a_phase);
        end
        drive_a(2, 1'b1);
        n_cmp++;
        if (a_fault !== 1'b0 || a_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL transition_clear got flt=%0d cnt=%0d required 0 1", a_fault, a_cnt);
        end
        drive_a(0, 1'b0);
    endtask

    task automatic test_yellow();
        drive_b(0, 1'b1);
        drive_b(0, 1'b0);
        drive_b(1, 1'b0);
        n_cmp++;
        if (b_fault !== 1'b0 || b_phase !== 2'd1 || b_running !== 1'b1) begin
            n_fail++;
            $display("FAIL yshort_p1 got flt=%0d ph=%0d run=%0d required 0 1 1", b_fault, b_phase, b_running);
        end
        drive_b(2, 1'b0);
        n_cmp++;
        if (b_code !== 3'd4 || b_fault !== 1'b1) begin
            n_fail++;
            $display("FAIL yshort got code=%0d flt=%0d required 4 1", b_code, b_fault);
        end
        drive_b(0, 1'b1);
        drive_b(0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            drive_b(1, 1'b0);
            n_cmp++;
            if (b_fault !== 1'b0) begin
                n_fail++;
                $display("FAIL ylong_p1_%0d got flt=%0d required 0", i, b_fault);
            end
        end
        drive_b(1, 1'b0);
        n_cmp++;
        if (b_code !== 3'd5 || b_phase !== 2'd1) begin
            n_fail++;
            $display("FAIL ylong got code=%0d ph=%0d required 5 1", b_code, b_phase);
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 254; i++) begin
            drive_a(1, 1'b0);
            drive_a(2, 1'b0);
            drive_a(3, 1'b0);
            drive_a(0, 1'b0);
        end
        n_cmp++;
        if (a_cnt !== 8'd255) begin
            n_fail++;
            $display("FAIL wrap_max got %0d required 255", a_cnt);
        end
        for (int k = 1; k >= 0; k--) begin
            drive_a(1, 1'b0);
            drive_a(2, 1'b0);
            drive_a(3, 1'b0);
            drive_a(0, 1'b0);
            n_cmp++;
            if (a_cnt !== 8'(1 - k)) begin
                n_fail++;
                $display("FAIL wrap_%0d got %0d required %0d", k, a_cnt, 1 - k);
            end
        end
    endtask

    task automatic test_reset_mid();
        #2;
        reset_n = 1'b0;
        ma = m_zero;
        mb = m_zero;
        #1;
        n_cmp++;
        if ({a_running, a_phase, a_fault, a_code, a_cnt} !== 15'd0) begin
            n_fail++;
            $display("FAIL async_reset_a got %b required 0", {a_running, a_phase, a_fault, a_code, a_cnt});
        end
        n_cmp++;
        if ({b_running, b_phase, b_fault, b_code, b_cnt} !== 11'd0) begin
            n_fail++;
            $display("FAIL async_reset_b got %b required 0", {b_running, b_phase, b_fault, b_code, b_cnt});
        end
        #2;
        reset_n = 1'b1;
    endtask

    task automatic test_random();
        int pa, pb, r;
        pa = 0;
        pb = 0;
        for (int s = 0; s < 400; s++) begin
            r = $urandom_range(0, 99);
            if (r >= 45 && r < 85) pa = (pa + 1) % 4;
            else if (r >= 85 && r < 92) pa = $urandom_range(0, 3);
            if (r >= 92) begin
                a_sa = 2'($urandom_range(0, 3));
                a_sb = 2'($urandom_range(0, 3));
            end else {a_sa, a_sb} = pair_of(pa);
            a_clr = ($urandom_range(0, 3) == 0);
            r = $urandom_range(0, 99);
            if (r >= 40 && r < 85) pb = (pb + 1) % 4;
            else if (r >= 85 && r < 92) pb = $urandom_range(0, 3);
            if (r >= 92) begin
                b_sa = 2'($urandom_range(0, 3));
                b_sb = 2'($urandom_range(0, 3));
            end else {b_sa, b_sb} = pair_of(pb);
            b_clr = ($urandom_range(0, 3) == 0);
            tick();
            n_cmp++;
            if ({a_running, a_phase, a_fault, a_code, a_cnt} !==
                {ma.mode == 1, 2'(ma.ph), ma.mode == 2, 3'(ma.code), 8'(ma.cnt)}) begin
                n_fail++;
                $display("FAIL rand_a step %0d got run=%0d ph=%0d flt=%0d code=%0d cnt=%0d required %0d %0d %0d %0d %0d",
                         s, a_running, a_phase, a_fault, a_code, a_cnt,
                         ma.mode == 1, ma.ph, ma.mode == 2, ma.code, ma.cnt);
            end
            n_cmp++;
            if ({b_running, b_phase, b_fault, b_code, b_cnt} !==
                {mb.mode == 1, 2'(mb.ph), mb.mode == 2, 3'(mb.code), 4'(mb.cnt)}) begin
                n_fail++;
                $display("FAIL rand_b step %0d got run=%0d ph=%0d flt=%0d code=%0d cnt=%0d required %0d %0d %0d %0d %0d",
                         s, b_running, b_phase, b_fault, b_code, b_cnt,
                         mb.mode == 1, mb.ph, mb.mode == 2, mb.code, mb.cnt);
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        m_zero = '{0, 0, 0, 0, 0};
        test_reset();
        test_cycle();
        test_conflict();
        test_priority();
        test_transition();
        test_yellow();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/traffic_signal_monitor.md
# traffic_signal_monitor

Passive checker on the light-code side of the two-road traffic signal controller. It samples the SA/SB light codes the controller drives and decodes them into a phase. It enforces the legal phase order, red-red exclusion and yellow dwell time, and latches the first fault with a code. It also counts completed signal cycles for the board status display.

## Interface
Parameters:
- YELLOW_CYCLES, default 1: exact number of consecutive clock edges a yellow phase must be sampled (1..15).
- CNT_W, default 8: width of cycle_count.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- SA  input  2  road A light code: 00 RED, 01 YELLOW, 10 GREEN, 11 illegal.
- SB  input  2  road B light code, same encoding.
- clear_fault  input  1  leaves FAULT when sampled high; ignored in other states.
- running  output  1  high while in RUN.
- phase  output  2  last legal phase sampled: 00 P0, 01 P1, 10 P2, 11 P3.
- fault  output  1  high while in FAULT.
- fault_code  output  3  0 none, 1 illegal encoding, 2 conflict, 3 illegal transition, 4 yellow short, 5 yellow long.
- cycle_count  output  CNT_W  completed P3->P0 transitions, wraps modulo 2^CNT_W.

## Operation
- Legal phases (SA,SB): P0=(GREEN,RED), P1=(YELLOW,RED), P2=(RED,GREEN), P3=(RED,YELLOW).
- Error classes:
  - Any 11 code is class 1.
  - Any other pair not in the legal list is class 2, e.g. (GREEN,GREEN) or (RED,RED).
- Legal transitions: hold, P0->P1, P1->P2, P2->P3, P3->P0. Any other change is class 3.
- dwell: 4-bit saturating count of consecutive edges the current phase has been sampled. It loads 1 on a phase change.
- Yellow checks (P1, P3):
  - A phase change out of yellow with dwell < YELLOW_CYCLES is class 4.
  - Sampling yellow while dwell already = YELLOW_CYCLES is class 5.
- Priority when several errors occur on one edge: 1 > 2 > 3 > 4/5. Only the highest is recorded.
- INIT state (after reset or clear):
  - Checks classes 1 and 2 only.
  - Stays in INIT on legal P1..P3.
  - On P0, enters RUN with phase=P0 and dwell=1.
- RUN state:
  - Checks all classes.
  - Updates phase and dwell on every legal sample.
  - Increments cycle_count on each P3->P0 transition.
- FAULT state:
  - fault_code, phase and cycle_count are frozen.
  - Inputs are ignored except clear_fault.
  - clear_fault high moves to INIT and clears fault and fault_code. cycle_count is retained.
- Simultaneous clear_fault and an error sample in FAULT: clear wins. That edge's sample is discarded, so the next check happens on the following edge.
- cycle_count is cleared only by reset_n.

## Timing
- Reset values (asynchronous, while reset_n low):
  - State INIT; running 0, phase 00, fault 0, fault_code 000, cycle_count 0, dwell 0.
- Latency:
  - An offending SA/SB present at edge k drives fault=1 and fault_code valid immediately after edge k.
  - running, phase and cycle_count likewise update after the edge that samples the causing input.
- fault stays high for at least one cycle. Leaving FAULT takes one edge with clear_fault=1. Checking resumes at the next edge.
- reset_n asserted mid-operation, including in FAULT, forces the reset values without waiting for a clock. Release is synchronised by the surrounding design.
- Outputs are registered; no combinational path from SA/SB to any output.

## Test plan
- Default parameters; after reset drive P0 x3, P1 x1, P2 x2, P3 x1, P0 -> running=1 after the first P0 edge; phase tracks each step; cycle_count=1 after the final P0 edge; fault stays 0.
- In RUN drive SA=10, SB=10 for one cycle -> fault=1, fault_code=2, phase frozen at the prior value. Then clear_fault=1 for one edge -> fault=0, code=0, running=0; a following P0 edge sets running=1.
- In RUN drive SA=11 together with SB=11 (a class 2 pair if decoded) -> fault_code=1, confirming priority.
- In RUN drive P0 then P2 directly -> fault_code=3 after the P2 edge. cycle_count is unchanged through the fault and the clear.
- YELLOW_CYCLES=2: P0, P1 x1, P2 -> fault_code=4. After clear and P0, drive P1 x3 -> fault_code=5 on the third P1 edge.
- With fault_code=5 latched, pull reset_n low between edges -> all outputs zero before the next rising clk, including cycle_count, which a wrap test drives 2^CNT_W-1 -> 0.
